// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, the fetch FSM state type
// and the "no register" specifier.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] NO_REG  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE,
        ERR
    } fsm_state_t;

endpackage

// File: rtl/fetch_sequencer_instr_len_dec.sv
// Combinational length decoder: maps an icode to its regids/valC needs,
// the total instruction length in bytes, and an invalid-opcode flag.
// Invalid opcodes report a length of 1 so the fetch stops after byte 0.
module instr_len_dec
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       need_regids,
    output logic       need_valc,
    output logic [3:0] length,
    output logic       invalid
);

    // Classify the opcode and derive the byte count.
    always_comb begin
        need_regids = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
                                    IOPQ, IPUSHQ, IPOPQ};
        need_valc   = icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
        invalid     = (icode > IPOPQ);
        length      = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-serial Y86-64 instruction fetch sequencer. Reads one instruction
// starting at pc_in over a one-byte request/ack memory port, decodes it and
// presents the fields with an instr_valid/out_ready handshake.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch that waits
// TIMEOUT_CYC cycles for mem_ack (imem_error=1, sticky ERR state).
module fetch_sequencer
    import y86_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic              instr_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              instr_err,
    output logic              imem_error
);

    fsm_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [3:0]        count_q;
    logic [3:0]        icode_q, ifun_q, ra_q, rb_q;
    logic [63:0]       valc_q;
    logic [ADDR_W-1:0] valp_q;
    logic              err_q, imem_err_q;

    logic [3:0]        dec_icode;
    logic              dec_regids, dec_valc, dec_invalid;
    logic [3:0]        dec_len;
    logic              last_byte;
    logic [2:0]        vidx;
    logic              timeout_hit;

    // Byte 0 is decoded straight off the bus; later bytes reuse the latched icode.
    assign dec_icode = (count_q == 4'd0) ? mem_rdata[7:4] : icode_q;

    instr_len_dec u_len_dec (
        .icode       (dec_icode),
        .need_regids (dec_regids),
        .need_valc   (dec_valc),
        .length      (dec_len),
        .invalid     (dec_invalid)
    );

    assign last_byte = (count_q == dec_len - 4'd1);
    // Position of the current byte inside the little-endian valC word.
    assign vidx      = 3'(count_q - 4'd1 - {3'b000, dec_regids});

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_q;

    // Count consecutive un-acked request cycles; restart on every new beat.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != FETCH || mem_ack)
            wait_q <= '0;
        else
            wait_q <= wait_q + WAIT_W'(1);
    end

    assign timeout_hit = (state_q == FETCH) && !mem_ack &&
                         (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
`else
    // No watchdog: wait forever; TIMEOUT_CYC has no effect in this build.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYC == 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and memory/handshake outputs.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_addr    = '0;
        instr_valid = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = FETCH;
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q + ADDR_W'(count_q);
                if (mem_ack && last_byte)
                    state_d = DONE;
                else if (timeout_hit)
                    state_d = ERR;
            end
            DONE: begin
                instr_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            ERR: begin
                state_d = ERR;
            end
        endcase
    end

    // Capture returned bytes into the decoded instruction fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= '0;
            count_q    <= '0;
            icode_q    <= '0;
            ifun_q     <= '0;
            ra_q       <= NO_REG;
            rb_q       <= NO_REG;
            valc_q     <= '0;
            valp_q     <= '0;
            err_q      <= 1'b0;
            imem_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pc_q    <= pc_in;
                        count_q <= '0;
                        ra_q    <= NO_REG;
                        rb_q    <= NO_REG;
                        valc_q  <= '0;
                        err_q   <= 1'b0;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        count_q <= count_q + 4'd1;
                        if (count_q == 4'd0) begin
                            icode_q <= mem_rdata[7:4];
                            ifun_q  <= mem_rdata[3:0];
                            err_q   <= dec_invalid;
                        end else if (count_q == 4'd1 && dec_regids) begin
                            ra_q <= mem_rdata[7:4];
                            rb_q <= mem_rdata[3:0];
                        end else begin
                            valc_q[{vidx, 3'b000} +: 8] <= mem_rdata;
                        end
                        if (last_byte)
                            valp_q <= pc_q + ADDR_W'(dec_len);
                    end else if (timeout_hit) begin
                        imem_err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign icode      = icode_q;
    assign ifun       = ifun_q;
    assign rA         = ra_q;
    assign rB         = rb_q;
    assign valC       = valc_q;
    assign valP       = valp_q;
    assign instr_err  = err_q;
    assign imem_error = imem_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed and randomized
// instructions answered by an in-bench byte memory, checked against a
// reference decode computed from the Y86-64 encoding rules.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] pc_in;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_valid, out_ready, busy, instr_err, imem_error;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  ibytes [10];
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
    logic [63:0] e_valc, e_valp;
    logic        e_err;
    int          e_len;

    fetch_sequencer #(.ADDR_W(64), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pc_in       (pc_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .instr_valid (instr_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .instr_err   (instr_err),
        .imem_error  (imem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the encoding rules.
    task automatic compute_expected(input logic [63:0] pc);
        int nr, nv;
        e_icode = ibytes[0][7:4];
        e_ifun  = ibytes[0][3:0];
        e_err   = (e_icode > 4'hB);
        nr = (e_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? 1 : 0;
        nv = (e_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) ? 1 : 0;
        e_len = 1 + nr + 8 * nv;
        e_ra  = (nr != 0) ? ibytes[1][7:4] : 4'hF;
        e_rb  = (nr != 0) ? ibytes[1][3:0] : 4'hF;
        e_valc = '0;
        if (nv != 0)
            for (int k = 0; k < 8; k++)
                e_valc = e_valc | (64'(ibytes[1 + nr + k]) << (8 * k));
        e_valp = pc + 64'(e_len);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({tag, "_mem_addr"}, mem_addr, 64'd0);
        chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
        chk({tag, "_icode"}, 64'(icode), 64'd0);
        chk({tag, "_ifun"}, 64'(ifun), 64'd0);
        chk({tag, "_rA"}, 64'(rA), 64'hF);
        chk({tag, "_rB"}, 64'(rB), 64'hF);
        chk({tag, "_valC"}, valC, 64'd0);
        chk({tag, "_valP"}, valP, 64'd0);
        chk({tag, "_ierr"}, 64'(instr_err), 64'd0);
        chk({tag, "_imem"}, 64'(imem_error), 64'd0);
    endtask

    // Full fetch of ibytes at pc with random ack gaps of 0..max_gap cycles.
    task automatic do_fetch(input logic [63:0] pc, input int unsigned max_gap, input bit check_lat);
        int cycles, acked, gap, hold;
        bit done;
        compute_expected(pc);
        pc_in = pc;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        acked = 0;
        done = 1'b0;
        gap = int'($urandom_range(max_gap, 0));
        while (!done && cycles < 300) begin
            if (instr_valid) begin
                done = 1'b1;
                mem_ack = 1'b0;
            end else begin
                mem_ack = 1'b0;
                if (mem_req) begin
                    chk("mem_addr", mem_addr, pc + 64'(acked));
                    chk("extra_req", 64'(acked < e_len), 64'd1);
                    if (gap == 0 && acked < 10) begin
                        mem_ack = 1'b1;
                        mem_rdata = ibytes[acked];
                        acked++;
                        gap = int'($urandom_range(max_gap, 0));
                    end else begin
                        mem_rdata = 8'($urandom);
                        if (gap > 0) gap--;
                    end
                end
                tick();
                cycles++;
            end
        end
        mem_ack = 1'b0;
        chk("valid_reached", 64'(done), 64'd1);
        if (check_lat)
            chk("latency", 64'(cycles), 64'(e_len + 1));
        chk("beats", 64'(acked), 64'(e_len));
        chk("icode", 64'(icode), 64'(e_icode));
        chk("ifun", 64'(ifun), 64'(e_ifun));
        chk("rA", 64'(rA), 64'(e_ra));
        chk("rB", 64'(rB), 64'(e_rb));
        chk("valC", valC, e_valc);
        chk("valP", valP, e_valp);
        chk("instr_err", 64'(instr_err), 64'(e_err));
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_no_req", 64'(mem_req), 64'd0);
        hold = int'($urandom_range(3, 0));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", 64'(instr_valid), 64'd1);
            chk("hold_valC", valC, e_valc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_valid", 64'(instr_valid), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_valP", valP, e_valp);
        chk("post_valC", valC, e_valc);
        chk("post_icode", 64'(icode), 64'(e_icode));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mem_ack = 1'b0;
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pc_in = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        out_ready = 1'b0;
        #2;
        apply_reset();
        check_reset_values("reset");

        // nop at 0x100, ack tied high
        ibytes = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_fetch(64'h100, 0, 1'b1);

        // irmovq $0x0102030405060708, %rbx
        ibytes = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        do_fetch(64'h200, 0, 1'b1);

        // jmp with random ack gaps
        ibytes = '{8'h70, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        do_fetch(64'h3000, 3, 1'b0);

        // invalid opcode stops after one byte
        ibytes = '{8'hC0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01};
        do_fetch(64'h400, 0, 1'b1);

        // rrmovq ending exactly at the top of the address space
        ibytes = '{8'h20, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_fetch(64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b1);

        // randomized instructions, addresses and ack gaps
        for (int t = 0; t < 16; t++) begin
            for (int b = 0; b < 10; b++)
                ibytes[b] = 8'($urandom);
            do_fetch({$urandom, $urandom}, 3, 1'b0);
        end

        // reset after the 4th byte of rmmovq; a late ack must be ignored
        ibytes = '{8'h40, 8'h12, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        pc_in = 64'h5000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_ack = 1'b1;
            mem_rdata = ibytes[b];
            tick();
        end
        chk("pre_reset_rA", 64'(rA), 64'h1);
        rst_n = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = ibytes[4];
        tick();
        check_reset_values("midreset");
        rst_n = 1'b1;
        tick();
        chk("late_ack_busy", 64'(busy), 64'd0);
        chk("late_ack_req", 64'(mem_req), 64'd0);
        mem_ack = 1'b0;
        do_fetch(64'h6000, 1, 1'b0);

        // memory that never acknowledges
        pc_in = 64'h7000;
        start = 1'b1;
        tick();
        start = 1'b0;
        mem_ack = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (15) tick();
        chk("to_before_imem", 64'(imem_error), 64'd0);
        chk("to_before_req", 64'(mem_req), 64'd1);
        tick();
        chk("to_imem", 64'(imem_error), 64'd1);
        chk("to_req", 64'(mem_req), 64'd0);
        chk("to_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        start = 1'b0;
        chk("err_sticky", 64'(busy), 64'd1);
        chk("err_sticky_imem", 64'(imem_error), 64'd1);
`else
        repeat (100) tick();
        chk("wait_req", 64'(mem_req), 64'd1);
        chk("wait_busy", 64'(busy), 64'd1);
        chk("wait_addr", mem_addr, 64'h7000);
        chk("wait_imem", 64'(imem_error), 64'd0);
        chk("wait_valid", 64'(instr_valid), 64'd0);
`endif
        apply_reset();
        check_reset_values("final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
